// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decoder scan sequencer (decode_scan_seq) and its
// dwell counter: FSM state encoding, select width, line count and direction
// encoding of the `dir` input.
// No ports (package).
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int SEL_W     = 4;
    localparam int NUM_LINES = 16;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : decode_pkg

// File: rtl/decode_scan_seq_dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Counts cycles spent on one scan index and strobes `wrap` on the cycle the
// count reaches DIV-1, at which point the count returns to 0.
//
// Parameters:
//   DIV    dwell cycles per index (1..255)
//   DIV_W  counter width
// Ports:
//   clk    input   system clock, rising edge
//   rst    input   asynchronous active-high reset
//   clear  input   force count to 0 (has priority over en)
//   en     input   advance the count this cycle
//   wrap   output  combinational strobe: en && count == DIV-1
// -----------------------------------------------------------------------------
module dwell_counter #(
    parameter int DIV   = 4,
    parameter int DIV_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic wrap
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // With DIV=1 LAST is 0, so wrap fires on every enabled cycle.
    assign wrap = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : dwell_counter

// File: rtl/decode_scan_seq.sv
// -----------------------------------------------------------------------------
// decode_scan_seq
// Self-timed index generator feeding the 4-to-16 decoder. Steps `sel` through
// all 16 lines, up or down, holding each index for DIV cycles. Single pass
// (ends with a one-cycle `done`) or continuous wrap. All outputs registered.
//
// Optional feature macro: DECODE_SCAN_MASK_EN
//   Defined   -> adds `mask` input; valid is qualified by mask[sel].
//   Undefined -> valid is high for every index visited in RUN.
//
// Parameters:
//   DIV    dwell cycles per index (1..255)
//   DIV_W  dwell counter width
// Ports:
//   clk    input      system clock, rising edge
//   rst    input      asynchronous active-high reset
//   start  input      begin a scan (honoured in IDLE only)
//   stop   input      abort (honoured in RUN; wins over start in IDLE)
//   dir    input      0 = down 15..0, 1 = up 0..15, latched at start
//   mode   input      0 = single pass, 1 = continuous, latched at start
//   mask   input [16] per-line valid enable (DECODE_SCAN_MASK_EN only)
//   sel    output [4] current index to decoder
//   valid  output     sel is an active scan index
//   busy   output     high while in RUN
//   done   output     one-cycle pulse at end of a single pass
// -----------------------------------------------------------------------------
module decode_scan_seq
    import decode_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int DIV_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 dir,
    input  logic                 mode,
`ifdef DECODE_SCAN_MASK_EN
    input  logic [NUM_LINES-1:0] mask,
`endif
    output logic [SEL_W-1:0]     sel,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             dir_q,   dir_d;
    logic             mode_q,  mode_d;

    logic             cnt_clear;
    logic             cnt_en;
    logic             cnt_wrap;
    logic [SEL_W-1:0] last_idx;

    dwell_counter #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .wrap  (cnt_wrap)
    );

    assign last_idx = (dir_q == DIR_UP) ? SEL_W'(NUM_LINES - 1) : '0;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d   = S_RUN;
                    dir_d     = dir;
                    mode_d    = mode;
                    sel_d     = (dir == DIR_UP) ? '0 : SEL_W'(NUM_LINES - 1);
                    cnt_clear = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_wrap) begin
                        if (sel_q == last_idx && !mode_q) begin
                            state_d = S_DONE;
                        end else begin
                            // Modulo-16 arithmetic gives the 15->0 / 0->15 wrap.
                            sel_d = (dir_q == DIR_UP) ? sel_q + 1'b1 : sel_q - 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
`ifdef DECODE_SCAN_MASK_EN
        valid_d = (state_d == S_RUN) && mask[sel_d];
`else
        valid_d = (state_d == S_RUN);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= DIR_DOWN;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    assign sel   = sel_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule : decode_scan_seq

// File: tb/tb_decode_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_decode_scan_seq
// Directed bench for decode_scan_seq. Four instances (DIV = 1, 2, 3, 4) share
// the control inputs; each scenario resets all of them and then follows the
// instance whose DIV the scenario needs. Expected outputs are pushed to a
// scoreboard queue and popped when the DUT output is sampled.
// Honours DECODE_SCAN_MASK_EN (adds the mask input and mask-aware expectations).
// -----------------------------------------------------------------------------
module tb_decode_scan_seq;
    import decode_pkg::*;

    logic clk = 1'b0;
    logic rst, start, stop, dir, mode;
`ifdef DECODE_SCAN_MASK_EN
    logic [15:0] mask;
`endif

    logic [3:0] sel1, sel2, sel3, sel4;
    logic valid1, valid2, valid3, valid4;
    logic busy1, busy2, busy3, busy4;
    logic done1, done2, done3, done4;

    always #5 clk = ~clk;

    decode_scan_seq #(.DIV(1), .DIV_W(8)) u_div1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
`ifdef DECODE_SCAN_MASK_EN
        .mask(mask),
`endif
        .sel(sel1), .valid(valid1), .busy(busy1), .done(done1));

    decode_scan_seq #(.DIV(2), .DIV_W(8)) u_div2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
`ifdef DECODE_SCAN_MASK_EN
        .mask(mask),
`endif
        .sel(sel2), .valid(valid2), .busy(busy2), .done(done2));

    decode_scan_seq #(.DIV(3), .DIV_W(8)) u_div3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
`ifdef DECODE_SCAN_MASK_EN
        .mask(mask),
`endif
        .sel(sel3), .valid(valid3), .busy(busy3), .done(done3));

    decode_scan_seq #(.DIV(4), .DIV_W(8)) u_div4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
`ifdef DECODE_SCAN_MASK_EN
        .mask(mask),
`endif
        .sel(sel4), .valid(valid4), .busy(busy4), .done(done4));

    typedef struct packed {
        logic [3:0] sel;
        logic       valid;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic obs_t o1(); return {sel1, valid1, busy1, done1}; endfunction
    function automatic obs_t o2(); return {sel2, valid2, busy2, done2}; endfunction
    function automatic obs_t o3(); return {sel3, valid3, busy3, done3}; endfunction
    function automatic obs_t o4(); return {sel4, valid4, busy4, done4}; endfunction

    task automatic push_exp(input logic [3:0] s, input logic v, input logic b, input logic d);
        obs_t e;
        e.sel   = s;
        e.valid = v;
        e.busy  = b;
        e.done  = d;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input obs_t obs);
        obs_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $error("FAIL %s: scoreboard empty, observed sel=%h valid=%b busy=%b done=%b",
                   tag, obs.sel, obs.valid, obs.busy, obs.done);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                tests_failed++;
                $error("FAIL %s: observed sel=%h valid=%b busy=%b done=%b, expected sel=%h valid=%b busy=%b done=%b",
                       tag, obs.sel, obs.valid, obs.busy, obs.done, e.sel, e.valid, e.busy, e.done);
            end
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        dir   = 1'b0;
        mode  = 1'b0;
`ifdef DECODE_SCAN_MASK_EN
        mask  = 16'hFFFF;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] s;
        logic       v;

        // ---------------- reset state ----------------
        do_reset();
        push_exp(4'h0, 1'b0, 1'b0, 1'b0);
        check("reset_div1", o1());
        push_exp(4'h0, 1'b0, 1'b0, 1'b0);
        check("reset_div4", o4());

        // ---------------- async reset mid-scan (DIV=4, up) ----------------
        dir   = 1'b1;
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        push_exp(4'h0, 1'b1, 1'b1, 1'b0);
        check("div4_first_index", o4());
        repeat (20) tick();
        push_exp(4'h5, 1'b1, 1'b1, 1'b0);
        check("div4_at_sel5", o4());
        #2;
        rst = 1'b1;
        #1;
        push_exp(4'h0, 1'b0, 1'b0, 1'b0);
        check("div4_async_reset", o4());
        tick();
        rst = 1'b0;
        tick();

        // ---------------- single pass down (DIV=1) ----------------
        do_reset();
        dir   = 1'b0;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_exp(4'(15 - i), 1'b1, 1'b1, 1'b0);
            check($sformatf("div1_down_i%0d", i), o1());
            tick();
        end
        push_exp(4'h0, 1'b0, 1'b0, 1'b1);
        check("div1_done_pulse", o1());
        tick();
        push_exp(4'h0, 1'b0, 1'b0, 1'b0);
        check("div1_done_cleared", o1());

        // ---------------- continuous up with dwell (DIV=3) ----------------
        // Also re-asserts start and flips dir mid-run; neither may disturb it.
        do_reset();
        dir   = 1'b1;
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 54; t++) begin
            push_exp(4'((t / 3) % 16), 1'b1, 1'b1, 1'b0);
            check($sformatf("div3_cont_t%0d", t), o3());
            if (t == 10) begin
                start = 1'b1;
                dir   = 1'b0;
                mode  = 1'b0;
            end
            if (t == 13) start = 1'b0;
            if (t == 54) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        push_exp(4'h2, 1'b0, 1'b0, 1'b0);
        check("div3_after_stop", o3());
        tick();
        push_exp(4'h2, 1'b0, 1'b0, 1'b0);
        check("div3_no_done", o3());

        // ---------------- start+stop together in IDLE ----------------
        start = 1'b1;
        stop  = 1'b1;
        tick();
        push_exp(4'h2, 1'b0, 1'b0, 1'b0);
        check("idle_start_stop", o3());
        start = 1'b0;
        stop  = 1'b0;
        tick();
        push_exp(4'h2, 1'b0, 1'b0, 1'b0);
        check("idle_still", o3());

        // ---------------- single pass up (DIV=2), masked when enabled ----------------
        do_reset();
`ifdef DECODE_SCAN_MASK_EN
        mask = 16'h00F0;
`endif
        dir   = 1'b1;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 32; t++) begin
            s = 4'(t / 2);
`ifdef DECODE_SCAN_MASK_EN
            v = mask[s];
`else
            v = 1'b1;
`endif
            push_exp(s, v, 1'b1, 1'b0);
            check($sformatf("div2_pass_t%0d", t), o2());
            tick();
        end
        push_exp(4'hF, 1'b0, 1'b0, 1'b1);
        check("div2_done_pulse", o2());
        tick();
        push_exp(4'hF, 1'b0, 1'b0, 1'b0);
        check("div2_idle", o2());

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_decode_scan_seq
